// File: rtl/bscan_chain_pkg.sv
// ============================================================================
//  Module      : bscan_chain_pkg
//  Description : Shared types and helpers for the boundary-scan chain slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bscan_chain_pkg;

    // TAP-issued cell controls, bundled so each cell sees one coherent word
    typedef struct packed {
        logic shift;
        logic capture;
        logic update;
    } bsc_ctrl_t;

    function automatic int bsc_chain_len(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bscan_chain_if.sv
// ============================================================================
//  Module      : bscan_chain_if
//  Description : TAP <-> boundary-scan chain serial/control interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bscan_chain_if;
    logic tdi_i;
    logic bsc_shift_i;
    logic bsc_capture_i;
    logic bsc_update_i;
    logic bsc_mode_i;
    logic tdo_o;

    modport master (
        output tdi_i,
        output bsc_shift_i,
        output bsc_capture_i,
        output bsc_update_i,
        output bsc_mode_i,
        input  tdo_o
    );

    modport slave (
        input  tdi_i,
        input  bsc_shift_i,
        input  bsc_capture_i,
        input  bsc_update_i,
        input  bsc_mode_i,
        output tdo_o
    );
endinterface

`default_nettype wire

// File: rtl/bscan_chain_bsc_cell.sv
// ============================================================================
//  Module      : bsc_cell
//  Description : One boundary-scan cell: shift flop, update flop, mode mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsc_cell
    import bscan_chain_pkg::*;
(
    input  wire logic      tck_i,
    input  wire logic      rst_n,
    input  wire bsc_ctrl_t ctrl_i,
    input  wire logic      mode_i,
    input  wire logic      si_i,
    input  wire logic      pi_i,
    output logic           so_o,
    output logic           po_o
);

    logic shift_q;
    logic shift_d;
    logic upd_q;
    logic upd_d;

    // Update samples shift_q before this edge's shift lands, so an illegal
    // update+shift edge still latches the pre-shift value.
    always_comb begin
        shift_d = shift_q;
        if (ctrl_i.shift) begin
            shift_d = si_i;
        end else if (ctrl_i.capture) begin
            shift_d = pi_i;
        end
        upd_d = ctrl_i.update ? shift_q : upd_q;
    end

    always_ff @(posedge tck_i or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            upd_q   <= upd_d;
        end
    end

    assign so_o = shift_q;
    assign po_o = mode_i ? upd_q : pi_i;

endmodule

`default_nettype wire

// File: rtl/bscan_chain.sv
// ============================================================================
//  Module      : bscan_chain
//  Description : Boundary-scan register: IN_W input cells then OUT_W output cells.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bscan_chain
    import bscan_chain_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
) (
    input  wire logic             tck_i,
    input  wire logic             rst_n,
    bscan_chain_if.slave          tap,
    input  wire logic [IN_W-1:0]  pad_in_i,
    output logic      [IN_W-1:0]  core_in_o,
    input  wire logic [OUT_W-1:0] core_out_i,
    output logic      [OUT_W-1:0] pad_out_o
);

    localparam int N = bsc_chain_len(IN_W, OUT_W);

    bsc_ctrl_t      ctrl;
    logic [N-1:0]   cell_pi;
    logic [N-1:0]   cell_si;
    logic [N-1:0]   cell_so;
    logic [N-1:0]   cell_po;

    assign ctrl.shift   = tap.bsc_shift_i;
    assign ctrl.capture = tap.bsc_capture_i;
    assign ctrl.update  = tap.bsc_update_i;

    // Cell k captures from / passes through the same net it drives past.
    assign cell_pi = {core_out_i, pad_in_i};
    assign cell_si = {tap.tdi_i, cell_so[N-1:1]};

    generate
        for (genvar k = 0; k < N; k++) begin : g_cell
            bsc_cell u_cell (
                .tck_i  (tck_i),
                .rst_n  (rst_n),
                .ctrl_i (ctrl),
                .mode_i (tap.bsc_mode_i),
                .si_i   (cell_si[k]),
                .pi_i   (cell_pi[k]),
                .so_o   (cell_so[k]),
                .po_o   (cell_po[k])
            );
        end
    endgenerate

    assign tap.tdo_o = cell_so[0];
    assign core_in_o = cell_po[IN_W-1:0];
    assign pad_out_o = cell_po[N-1:IN_W];

endmodule

`default_nettype wire

// File: tb/tb_bscan_chain.sv
// ============================================================================
//  Module      : tb_bscan_chain
//  Description : Self-checking bench for bscan_chain with IN_W = OUT_W = 4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bscan_chain;

    localparam int N = 8;

    logic       tck = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pad_in;
    logic [3:0] core_in;
    logic [3:0] core_out;
    logic [3:0] pad_out;

    always #5 tck = ~tck;

    bscan_chain_if tap_if ();

    bscan_chain #(.IN_W(4), .OUT_W(4)) dut (
        .tck_i      (tck),
        .rst_n      (rst_n),
        .tap        (tap_if),
        .pad_in_i   (pad_in),
        .core_in_o  (core_in),
        .core_out_i (core_out),
        .pad_out_o  (pad_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: chain as a FIFO of bits (front = tdo end), update stage as array
    bit       mq[$];
    bit [7:0] mupd;

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < N; i++) mq.push_back(1'b0);
        mupd = '0;
    endfunction

    function automatic void model_edge(bit sh, bit cap, bit up, bit tdi,
                                       bit [3:0] pad, bit [3:0] core);
        if (up) for (int i = 0; i < N; i++) mupd[i] = mq[i];
        if (sh) begin
            void'(mq.pop_front());
            mq.push_back(tdi);
        end else if (cap) begin
            mq.delete();
            for (int i = 0; i < 4; i++) mq.push_back(pad[i]);
            for (int i = 0; i < 4; i++) mq.push_back(core[i]);
        end
    endfunction

    task automatic drive(input bit sh, input bit cap, input bit up, input bit mode,
                         input bit tdi, input bit [3:0] pad, input bit [3:0] core);
        tap_if.bsc_shift_i   = sh;
        tap_if.bsc_capture_i = cap;
        tap_if.bsc_update_i  = up;
        tap_if.bsc_mode_i    = mode;
        tap_if.tdi_i         = tdi;
        pad_in               = pad;
        core_out             = core;
    endtask

    task automatic tick();
        @(posedge tck);
        if (rst_n)
            model_edge(tap_if.bsc_shift_i, tap_if.bsc_capture_i, tap_if.bsc_update_i,
                       tap_if.tdi_i, pad_in, core_out);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit [3:0] eci;
        bit [3:0] epo;
        eci = tap_if.bsc_mode_i ? mupd[3:0] : pad_in;
        epo = tap_if.bsc_mode_i ? mupd[7:4] : core_out;
        chk1({tag, "_tdo"}, tap_if.tdo_o, mq[0]);
        chk4({tag, "_core_in"}, core_in, eci);
        chk4({tag, "_pad_out"}, pad_out, epo);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 4'h0, 4'h0);
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit       sh, cap, up, mode, tdi;
        bit [3:0] pad, core;
        bit       etdo;
        bit [3:0] eci, epo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit sh, bit cap, bit up, bit mode, bit tdi,
                                bit [3:0] pad, bit [3:0] core,
                                bit etdo, bit [3:0] eci, bit [3:0] epo);
        vec_t v;
        v.sh = sh; v.cap = cap; v.up = up; v.mode = mode; v.tdi = tdi;
        v.pad = pad; v.core = core; v.etdo = etdo; v.eci = eci; v.epo = epo;
        tbl.push_back(v);
    endfunction

    initial begin
        bit [7:0] seqv;
        bit [7:0] c3v;
        bit       e4[4];

        // Capture 6/9 then shift it out, expecting 0x96 LSB-first
        seqv = 8'h4B;
        c3v  = 8'hC3;
        add(0, 1, 0, 0, 0, 4'h6, 4'h9, 1'b0, 4'h6, 4'h9);
        for (int k = 0; k < 8; k++) add(1, 1, 0, 0, 0, 4'h6, 4'h9, seqv[k], 4'h6, 4'h9);
        // Preload 0xC3, update, then switch to EXTEST drive
        for (int k = 0; k < 8; k++) add(1, 1, 0, 0, c3v[k], 4'h6, 4'h9, k == 7, 4'h6, 4'h9);
        add(0, 0, 1, 0, 0, 4'h6, 4'h9, 1'b1, 4'h6, 4'h9);
        add(0, 0, 0, 1, 0, 4'h6, 4'h9, 1'b1, 4'h3, 4'hC);
        e4 = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) add(1, 1, 0, 1, 0, 4'h6, 4'h9, e4[k], 4'h3, 4'hC);

        // Reset: pass-through holds, tdo low, update stage cleared
        drive(0, 0, 0, 0, 0, 4'hA, 4'h5);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk4("rst_core_in", core_in, 4'hA);
        chk4("rst_pad_out", pad_out, 4'h5);
        chk1("rst_tdo", tap_if.tdo_o, 1'b0);
        tap_if.bsc_mode_i = 1'b1;
        #1;
        chk4("rst_mode1_core_in", core_in, 4'h0);
        chk4("rst_mode1_pad_out", pad_out, 4'h0);
        tap_if.bsc_mode_i = 1'b0;
        tick();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].sh, tbl[i].cap, tbl[i].up, tbl[i].mode, tbl[i].tdi,
                  tbl[i].pad, tbl[i].core);
            tick();
            chk1($sformatf("vec%0d_tdo", i), tap_if.tdo_o, tbl[i].etdo);
            chk4($sformatf("vec%0d_core_in", i), core_in, tbl[i].eci);
            chk4($sformatf("vec%0d_pad_out", i), pad_out, tbl[i].epo);
        end

        // Mode gating: update 0xFF in functional mode, then raise mode without an edge
        do_reset();
        drive(1, 1, 0, 0, 1, 4'h2, 4'h7);
        repeat (8) tick();
        drive(0, 0, 1, 0, 0, 4'h2, 4'h7);
        tick();
        drive(0, 0, 0, 0, 0, 4'h2, 4'h7);
        #1;
        chk4("gate_m0_core_in", core_in, 4'h2);
        chk4("gate_m0_pad_out", pad_out, 4'h7);
        tap_if.bsc_mode_i = 1'b1;
        #1;
        chk4("gate_m1_core_in", core_in, 4'hF);
        chk4("gate_m1_pad_out", pad_out, 4'hF);

        // Priority: shift+capture must shift, not load the all-zero pads
        do_reset();
        drive(1, 1, 0, 0, 1, 4'h0, 4'h0);
        repeat (8) tick();
        drive(1, 1, 0, 0, 1, 4'h0, 4'h0);
        tick();
        drive(0, 0, 1, 0, 0, 4'h0, 4'h0);
        tick();
        drive(0, 0, 0, 1, 0, 4'h0, 4'h0);
        #1;
        chk4("prio_core_in", core_in, 4'hF);
        chk4("prio_pad_out", pad_out, 4'hF);
        drive(0, 1, 0, 1, 0, 4'h0, 4'h0);
        tick();
        drive(0, 0, 1, 1, 0, 4'h0, 4'h0);
        tick();
        chk4("cap_core_in", core_in, 4'h0);
        chk4("cap_pad_out", pad_out, 4'h0);

        // Reset mid-shift, update pulsed while held in reset
        do_reset();
        drive(1, 1, 0, 0, 1, 4'h5, 4'h5);
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 1, 0, 0, 4'h5, 4'h5);
        tick();
        chk1("abort_tdo", tap_if.tdo_o, 1'b0);
        tap_if.bsc_mode_i = 1'b1;
        #1;
        chk4("abort_core_in", core_in, 4'h0);
        chk4("abort_pad_out", pad_out, 4'h0);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 4'h5, 4'h5);
        tick();
        chk1("abort_post_tdo", tap_if.tdo_o, 1'b0);
        chk4("abort_post_core_in", core_in, 4'h0);
        chk4("abort_post_pad_out", pad_out, 4'h0);

        // Randomized traffic, including illegal update+shift and async resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            #1;
            check_model($sformatf("rnd%0d_pre", i));
            tick();
            check_model($sformatf("rnd%0d_post", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
